// File: rtl/dsp_fe_lane_lut_dbuf.sv
// Double-buffered lane calibration LUT with identity-seed walker and atomic bank swap.
// Optional shadow readback port (i_rb_addr/o_rb_data) enabled by DSP_FE_LUT_READBACK_EN.
module dsp_fe_lane_lut_dbuf #(
    parameter int INPUT_WIDTH    = 6,
    parameter int OUTPUT_WIDTH   = 8,
    parameter int REUSE_RANK     = 4,
    parameter int PIPELINE_DEPTH = 2
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_en,
    input  logic [REUSE_RANK-1:0][INPUT_WIDTH-1:0]   i_addr_ri_lane,
    input  logic                                     i_cfg_mode_mission,
    input  logic                                     i_wr_valid,
    input  logic [INPUT_WIDTH-1:0]                   i_wr_addr,
    input  logic [OUTPUT_WIDTH-1:0]                  i_wr_data,
    output logic                                     o_wr_ready,
    input  logic                                     i_seed_req,
    input  logic                                     i_swap_req,
    output logic                                     o_swap_ack,
    output logic                                     o_busy,
    output logic                                     o_bank_sel,
`ifdef DSP_FE_LUT_READBACK_EN
    input  logic [INPUT_WIDTH-1:0]                   i_rb_addr,
    output logic [OUTPUT_WIDTH-1:0]                  o_rb_data,
`endif
    output logic [REUSE_RANK-1:0][OUTPUT_WIDTH-1:0]  o_dat_ro_lane
);

    localparam int N = 2 ** INPUT_WIDTH;
    localparam logic [INPUT_WIDTH-1:0] ONE  = 1;
    localparam logic [INPUT_WIDTH-1:0] LAST = '1;

    typedef enum logic {IDLE, SEED} state_t;

    state_t                   state, state_n;
    logic [INPUT_WIDTH-1:0]   cnt, cnt_n;
    logic                     pend, pend_n;
    logic                     swap_go, seed_we, wr_we;
    logic                     shadow;
    logic [OUTPUT_WIDTH-1:0]  seed_val;
    logic [OUTPUT_WIDTH-1:0]  bank [2][N];
    logic [REUSE_RANK-1:0][OUTPUT_WIDTH-1:0] look;

    assign shadow     = ~o_bank_sel;
    assign o_busy     = (state == SEED);
    assign o_wr_ready = (state == IDLE);

    generate
        if (OUTPUT_WIDTH == INPUT_WIDTH) begin : g_id_eq
            assign seed_val = cnt;
        end else if (OUTPUT_WIDTH > INPUT_WIDTH) begin : g_id_up
            assign seed_val = {cnt, {(OUTPUT_WIDTH-INPUT_WIDTH){1'b0}}};
        end else begin : g_id_dn
            assign seed_val = cnt[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pend       <= 1'b0;
            o_bank_sel <= 1'b0;
            o_swap_ack <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pend       <= pend_n;
            o_bank_sel <= o_bank_sel ^ swap_go;
            // ack follows the executed swap only, so it never stretches over a stall
            o_swap_ack <= swap_go;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        swap_go = 1'b0;
        seed_we = 1'b0;
        wr_we   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_en) begin
                    wr_we   = i_wr_valid;
                    swap_go = i_swap_req;
                    if (i_seed_req) begin
                        state_n = SEED;
                        cnt_n   = '0;
                    end
                end
            end
            SEED: begin
                if (i_en) begin
                    seed_we = 1'b1;
                    cnt_n   = cnt + ONE;
                    pend_n  = pend | i_swap_req;
                    if (cnt == LAST) begin
                        state_n = IDLE;
                        swap_go = pend | i_swap_req;
                        pend_n  = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < N; a++) begin
                    bank[b][a] <= '0;
                end
            end
        end else if (seed_we) begin
            bank[shadow][cnt] <= seed_val;
        end else if (wr_we) begin
            bank[shadow][i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        look = '0;
        for (int l = 0; l < REUSE_RANK; l++) begin
            if (i_cfg_mode_mission) begin
                look[l] = bank[o_bank_sel][i_addr_ri_lane[l]];
            end
        end
    end

    generate
        if (PIPELINE_DEPTH <= 1) begin : g_comb
            assign o_dat_ro_lane = look;
        end else begin : g_pipe
            logic [REUSE_RANK-1:0][OUTPUT_WIDTH-1:0] stg [PIPELINE_DEPTH-1];
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int s = 0; s < PIPELINE_DEPTH-1; s++) begin
                        stg[s] <= '0;
                    end
                end else if (i_en) begin
                    stg[0] <= look;
                    for (int s = 1; s < PIPELINE_DEPTH-1; s++) begin
                        stg[s] <= stg[s-1];
                    end
                end
            end
            assign o_dat_ro_lane = stg[PIPELINE_DEPTH-2];
        end
    endgenerate

`ifdef DSP_FE_LUT_READBACK_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rb_data <= '0;
        end else if (i_en) begin
            o_rb_data <= bank[shadow][i_rb_addr];
        end
    end
`endif

endmodule

// File: tb/tb_dsp_fe_lane_lut_dbuf.sv
// Randomized self-checking bench for dsp_fe_lane_lut_dbuf against a table-level model.
// Directed scenarios pin the model; a compare process checks every cycle.
module tb_dsp_fe_lane_lut_dbuf;

    localparam int IW = 6;
    localparam int OW = 8;
    localparam int R  = 4;
    localparam int PD = 2;
    localparam int N  = 2 ** IW;

    typedef logic [R-1:0][OW-1:0] lanes_t;

    logic                  i_clk, i_rst, i_en;
    logic [R-1:0][IW-1:0]  i_addr_ri_lane;
    logic                  i_cfg_mode_mission;
    logic                  i_wr_valid;
    logic [IW-1:0]         i_wr_addr;
    logic [OW-1:0]         i_wr_data;
    logic                  o_wr_ready;
    logic                  i_seed_req, i_swap_req;
    logic                  o_swap_ack, o_busy, o_bank_sel;
    lanes_t                o_dat_ro_lane;
`ifdef DSP_FE_LUT_READBACK_EN
    logic [IW-1:0]         i_rb_addr;
    logic [OW-1:0]         o_rb_data;
`endif

    dsp_fe_lane_lut_dbuf #(
        .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
        .REUSE_RANK(R), .PIPELINE_DEPTH(PD)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
        .i_addr_ri_lane(i_addr_ri_lane),
        .i_cfg_mode_mission(i_cfg_mode_mission),
        .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .i_seed_req(i_seed_req), .i_swap_req(i_swap_req),
        .o_swap_ack(o_swap_ack), .o_busy(o_busy),
        .o_bank_sel(o_bank_sel),
`ifdef DSP_FE_LUT_READBACK_EN
        .i_rb_addr(i_rb_addr), .o_rb_data(o_rb_data),
`endif
        .o_dat_ro_lane(o_dat_ro_lane)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: two plain tables, an active index, and a countdown of seed entries left
    int     bk [2][N];
    int     sel, busy_left, sidx, ackm;
    bit     pend;
    lanes_t pq [PD];
    int     rbm;

    function automatic int ident(input int c);
        if (OW >= IW) return (c << (OW - IW)) & ((1 << OW) - 1);
        return c >> (IW - OW);
    endfunction

    function automatic lanes_t mlook();
        lanes_t v = '0;
        for (int l = 0; l < R; l++)
            if (i_cfg_mode_mission) v[l] = OW'(bk[sel][int'(i_addr_ri_lane[l])]);
        return v;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < N; a++) bk[b][a] = 0;
            sel = 0; busy_left = 0; sidx = 0; ackm = 0; pend = 0; rbm = 0;
            for (int s = 0; s < PD; s++) pq[s] = '0;
        end else begin
            ackm = 0;
            if (i_en) begin
                lanes_t lk;
                lk = mlook();
`ifdef DSP_FE_LUT_READBACK_EN
                rbm = bk[1-sel][int'(i_rb_addr)];
`endif
                if (PD > 1) begin
                    for (int s = PD-2; s > 0; s--) pq[s] = pq[s-1];
                    pq[0] = lk;
                end
                if (busy_left == 0) begin
                    if (i_wr_valid) bk[1-sel][int'(i_wr_addr)] = int'(i_wr_data);
                    if (i_swap_req) begin sel = 1 - sel; ackm = 1; end
                    if (i_seed_req) begin busy_left = N; sidx = 0; end
                end else begin
                    bk[1-sel][sidx] = ident(sidx);
                    sidx++;
                    busy_left--;
                    if (i_swap_req) pend = 1;
                    if (busy_left == 0 && pend) begin
                        sel = 1 - sel; ackm = 1; pend = 0;
                    end
                end
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_on) begin
            lanes_t expd;
            expd = (PD > 1) ? pq[PD-2] : mlook();
            chk("dat", 64'(o_dat_ro_lane), 64'(expd));
            chk("bank_sel", 64'(o_bank_sel), 64'(sel));
            chk("busy", 64'(o_busy), 64'(busy_left != 0));
            chk("wr_ready", 64'(o_wr_ready), 64'(busy_left == 0));
            chk("swap_ack", 64'(o_swap_ack), 64'(ackm));
`ifdef DSP_FE_LUT_READBACK_EN
            chk("rb_data", 64'(o_rb_data), 64'(rbm));
`endif
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    int n;

    initial begin
        i_rst = 0; i_en = 1; i_addr_ri_lane = '0; i_cfg_mode_mission = 0;
        i_wr_valid = 0; i_wr_addr = '0; i_wr_data = '0;
        i_seed_req = 0; i_swap_req = 0;
`ifdef DSP_FE_LUT_READBACK_EN
        i_rb_addr = '0;
`endif
        #1 i_rst = 1;
        chk_on = 1;
        tick(); tick();
        i_rst = 0;

        // zeroed banks in mission mode
        i_cfg_mode_mission = 1;
        i_addr_ri_lane = {6'd63, 6'd20, 6'd10, 6'd5};
        tick(); tick();
        @(negedge i_clk);
        chk("t1_dat", 64'(o_dat_ro_lane), 64'd0);
        chk("t1_sel", 64'(o_bank_sel), 64'd0);
        chk("t1_rdy", 64'(o_wr_ready), 64'd1);

        // write, swap, lookup
        i_wr_valid = 1; i_wr_addr = 6'd5; i_wr_data = 8'hA5;
        tick();
        i_wr_valid = 0; i_swap_req = 1;
        tick();
        i_swap_req = 0;
        i_addr_ri_lane[0] = 6'd5;
        @(negedge i_clk);
        chk("t2_ack", 64'(o_swap_ack), 64'd1);
        chk("t2_sel", 64'(o_bank_sel), 64'd1);
        tick();
        @(negedge i_clk);
        chk("t2_dat", 64'(o_dat_ro_lane[0]), 64'hA5);
        chk("t2_ack_low", 64'(o_swap_ack), 64'd0);

        // seed with writes offered during it
        i_seed_req = 1;
        tick();
        i_seed_req = 0;
        n = 0;
        @(negedge i_clk);
        while (o_busy && n < 200) begin
            n++;
            @(posedge i_clk); #1;
            i_wr_valid = 1'($urandom);
            i_wr_addr = IW'($urandom);
            i_wr_data = OW'($urandom);
            @(negedge i_clk);
        end
        i_wr_valid = 0;
        chk("t3_busy_len", 64'(n), 64'd64);
        i_swap_req = 1;
        tick();
        i_swap_req = 0;
        i_addr_ri_lane = {4{6'd63}};
        tick();
        @(negedge i_clk);
        chk("t3_dat63", 64'(o_dat_ro_lane), 64'hFCFCFCFC);

        // swap requested mid-seed
        i_seed_req = 1;
        tick();
        i_seed_req = 0;
        repeat (10) tick();
        i_swap_req = 1;
        tick();
        i_swap_req = 0;
        @(negedge i_clk);
        chk("t4_hold", 64'(o_bank_sel), 64'd0);
        n = 0;
        while (o_busy && n < 200) begin
            n++;
            @(posedge i_clk); #1;
            @(negedge i_clk);
        end
        chk("t4_ack", 64'(o_swap_ack), 64'd1);
        chk("t4_sel", 64'(o_bank_sel), 64'd1);

        // stall mid-seed
        i_seed_req = 1;
        tick();
        i_seed_req = 0;
        n = 0;
        @(negedge i_clk);
        while (o_busy && n < 300) begin
            n++;
            @(posedge i_clk); #1;
            i_en = !(n >= 20 && n < 23);
            i_addr_ri_lane = (R*IW)'($urandom);
            @(negedge i_clk);
        end
        i_en = 1;
        chk("t5_busy_len", 64'(n), 64'd67);

`ifdef DSP_FE_LUT_READBACK_EN
        i_wr_valid = 1; i_wr_addr = 6'd7; i_wr_data = 8'h3C;
        tick();
        i_wr_valid = 0; i_rb_addr = 6'd7;
        tick();
        @(negedge i_clk);
        chk("t6_rb", 64'(o_rb_data), 64'h3C);
`endif

        // reset in the middle of a seed
        i_seed_req = 1;
        tick();
        i_seed_req = 0;
        repeat (20) tick();
        i_rst = 1;
        @(negedge i_clk);
        chk("t7_busy", 64'(o_busy), 64'd0);
        chk("t7_sel", 64'(o_bank_sel), 64'd0);
        chk("t7_dat", 64'(o_dat_ro_lane), 64'd0);
        tick();
        i_rst = 0;

        repeat (3000) begin
            i_en = ($urandom_range(0, 9) != 0);
            i_cfg_mode_mission = ($urandom_range(0, 7) != 0);
            i_addr_ri_lane = (R*IW)'($urandom);
            i_wr_valid = 1'($urandom);
            i_wr_addr = IW'($urandom);
            i_wr_data = OW'($urandom);
            i_seed_req = ($urandom_range(0, 39) == 0);
            i_swap_req = ($urandom_range(0, 9) == 0);
`ifdef DSP_FE_LUT_READBACK_EN
            i_rb_addr = IW'($urandom);
`endif
            i_rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        i_rst = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
